cnt_core: RTL and testbench

Counter engine of the SLG46620 CNT0 macrocell. It is the counting side of the delay/counter control handshake. It takes the active-low clear and count-enable produced by the delay-mode logic and returns the running count that logic compares against the register value. It also supplies a clock prescaler, a wrap or one-shot terminal behaviour, and a registered terminal-count pulse for the counter macrocell output path.

---
 rtl/slg46620_cnt0_pkg.sv | 42 ++++
 rtl/cnt_prescaler.sv | 56 +++++
 rtl/cnt_core.sv | 91 +++++++++
 tb/tb_cnt_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slg46620_cnt0_pkg.sv
// Shared types and helpers for the SLG46620 CNT0 counter engine.
package slg46620_cnt0_pkg;

    typedef enum logic [2:0] {
        Div1     = 3'd0,
        Div2     = 3'd1,
        Div4     = 3'd2,
        Div8     = 3'd3,
        Div12    = 3'd4,
        Div24    = 3'd5,
        Div64    = 3'd6,
        Div_Rsvd = 3'd7
    } cnt_prescale_e;

    typedef enum logic {
        Cnt_Wrap     = 1'b0,
        Cnt_One_Shot = 1'b1
    } cnt_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_e;

    // The reserved code falls back to an undivided clock enable.
    function automatic logic [6:0] prescale_divisor(input cnt_prescale_e sel);
        logic [6:0] n;
        case (sel)
            Div1:    n = 7'd1;
            Div2:    n = 7'd2;
            Div4:    n = 7'd4;
            Div8:    n = 7'd8;
            Div12:   n = 7'd12;
            Div24:   n = 7'd24;
            Div64:   n = 7'd64;
            default: n = 7'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Clock-enable divider: issues tick once every N enabled cycles.
module cnt_prescaler
    import slg46620_cnt0_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_clear,
    input  logic          i_enable,
    input  cnt_prescale_e i_select,
    output logic          o_tick
);

    logic [5:0] div_q;
    logic [5:0] div_d;
    logic [6:0] period_q;
    logic [6:0] period_d;
    logic [6:0] period_s;
    logic       tick_s;

    // The divisor is sampled at the start of each period so a new select lands at the wrap.
    always_comb begin
        period_s = period_q;
        div_d    = div_q;
        period_d = period_q;
        if (div_q == 6'd0) begin
            period_s = prescale_divisor(i_select);
        end else begin
            period_s = period_q;
        end
        tick_s = i_enable && !i_clear && ({1'b0, div_q} == (period_s - 7'd1));
        if (i_clear || !i_enable) begin
            div_d    = 6'd0;
            period_d = 7'd1;
        end else if (tick_s) begin
            div_d    = 6'd0;
            period_d = period_s;
        end else begin
            div_d    = div_q + 6'd1;
            period_d = period_s;
        end
    end

    // Divider phase and latched period.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            div_q    <= 6'd0;
            period_q <= 7'd1;
        end else begin
            div_q    <= div_d;
            period_q <= period_d;
        end
    end

    assign o_tick = tick_s;

endmodule

// File: rtl/cnt_core.sv
// CNT0 counter engine: prescaled count, wrap/one-shot terminal behaviour, registered outputs.
module cnt_core
    import slg46620_cnt0_pkg::*;
#(
    parameter int BIT_WIDTH = 14
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_cnt_reset,
    input  logic                 i_cnt_allow,
    input  logic [BIT_WIDTH-1:0] i_data_from_register,
    input  cnt_prescale_e        i_prescale_select,
    input  cnt_mode_e            i_cnt_mode_select,
    output logic [BIT_WIDTH-1:0] o_counter,
    output logic                 o_terminal,
    output logic                 o_busy
);

    cnt_state_e           state_q;
    logic [BIT_WIDTH-1:0] counter_q;
    logic                 terminal_q;
    logic                 busy_q;
    logic                 tick_s;
    logic                 div_enable_s;

    assign div_enable_s = (state_q == RUN) && i_cnt_allow;

    cnt_prescaler u_prescaler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (!i_cnt_reset),
        .i_enable  (div_enable_s),
        .i_select  (i_prescale_select),
        .o_tick    (tick_s)
    );

    // Control FSM with count and registered output flags; the counter only increments
    // while below data, so it can never overflow.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_cnt_reset) begin
            state_q    <= IDLE;
            counter_q  <= {BIT_WIDTH{1'b0}};
            terminal_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            terminal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cnt_allow) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!i_cnt_allow) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick_s) begin
                        if (counter_q >= i_data_from_register) begin
                            terminal_q <= 1'b1;
                            if (i_cnt_mode_select == Cnt_One_Shot) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                            end else begin
                                counter_q <= {BIT_WIDTH{1'b0}};
                            end
                        end else begin
                            counter_q <= counter_q + {{(BIT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_counter  = counter_q;
    assign o_terminal = terminal_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_cnt_core.sv
// Self-checking bench for cnt_core against a cycle-level behavioural model.
module tb_cnt_core;
    import slg46620_cnt0_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cnt_reset = 1'b1;
    logic          allow = 1'b0;
    logic [13:0]   data = 14'd0;
    cnt_prescale_e sel = Div1;
    cnt_mode_e     mode = Cnt_Wrap;
    logic [13:0]   o_counter;
    logic          o_terminal;
    logic          o_busy;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    bit          m_term = 1'b0;
    logic [13:0] m_count = 14'd0;
    int          m_phase = 0;
    int          m_per = 1;
    int          divs [8] = '{1, 2, 4, 8, 12, 24, 64, 1};

    cnt_core #(.BIT_WIDTH(14)) dut (
        .i_clk                (clk),
        .i_reset_n            (rst_n),
        .i_cnt_reset          (cnt_reset),
        .i_cnt_allow          (allow),
        .i_data_from_register (data),
        .i_prescale_select    (sel),
        .i_cnt_mode_select    (mode),
        .o_counter            (o_counter),
        .o_terminal           (o_terminal),
        .o_busy               (o_busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (!rst_n || !cnt_reset) begin
            m_run = 1'b0; m_done = 1'b0; m_term = 1'b0; m_count = 14'd0; m_phase = 0;
        end else begin
            m_term = 1'b0;
            if (m_done) begin
                m_done = 1'b1;
            end else if (!m_run) begin
                if (allow) begin m_run = 1'b1; m_phase = 0; end
            end else if (!allow) begin
                m_run = 1'b0; m_phase = 0;
            end else begin
                if (m_phase == 0) m_per = divs[int'(sel)];
                m_phase++;
                if (m_phase == m_per) begin
                    m_phase = 0;
                    if (m_count >= data) begin
                        m_term = 1'b1;
                        if (mode == Cnt_Wrap) m_count = 14'd0;
                        else begin m_done = 1'b1; m_run = 1'b0; end
                    end else begin
                        m_count = m_count + 14'd1;
                    end
                end
            end
        end
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        cnt_reset = 1'b0;
        clk_step();
        cnt_reset = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; allow = 1'b1; cnt_reset = 1'b1;
        clk_step(); clk_step();
        n_checks++;
        if ({o_counter, o_terminal, o_busy} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: got cnt=%0d term=%0b busy=%0b, want all 0", o_counter, o_terminal, o_busy);
        end
        allow = 1'b0; rst_n = 1'b1;
        clk_step();
    endtask

    task automatic test_wrap_n1();
        int pulses = 0;
        do_clear();
        sel = Div1; data = 14'd5; mode = Cnt_Wrap; allow = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            pulses += int'(o_terminal);
            n_checks++;
            if ({o_counter, o_terminal, o_busy} !== {m_count, m_term, m_run}) begin
                n_fail++;
                $display("FAIL wrap_n1 cyc %0d: got cnt=%0d term=%0b busy=%0b, want cnt=%0d term=%0b busy=%0b",
                         i, o_counter, o_terminal, o_busy, m_count, m_term, m_run);
            end
        end
        // edges 1..5 count to 5, edge 6 wraps, edge 12 and 18 wrap again
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL wrap_n1_pulses: got %0d, want 3", pulses);
        end
    endtask

    task automatic test_one_shot_n4();
        int pulses = 0;
        do_clear();
        sel = Div4; data = 14'd3; mode = Cnt_One_Shot; allow = 1'b1;
        for (int i = 0; i < 21; i++) begin
            clk_step();
            pulses += int'(o_terminal);
            n_checks++;
            if ({o_counter, o_terminal, o_busy} !== {m_count, m_term, m_run}) begin
                n_fail++;
                $display("FAIL one_shot cyc %0d: got cnt=%0d term=%0b busy=%0b, want cnt=%0d term=%0b busy=%0b",
                         i, o_counter, o_terminal, o_busy, m_count, m_term, m_run);
            end
        end
        n_checks++;
        if (o_counter !== 14'd3 || o_busy !== 1'b0 || pulses != 1) begin
            n_fail++;
            $display("FAIL one_shot_end: got cnt=%0d busy=%0b pulses=%0d, want 3 0 1", o_counter, o_busy, pulses);
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        sel = Div2; data = 14'd100; mode = Cnt_Wrap; allow = 1'b1;
        for (int i = 0; i < 100 && o_counter != 14'd7; i++) clk_step();
        n_checks++;
        if (o_counter !== 14'd7) begin
            n_fail++;
            $display("FAIL clear_reach7: got cnt=%0d, want 7", o_counter);
        end
        cnt_reset = 1'b0;
        clk_step();
        cnt_reset = 1'b1;
        n_checks++;
        if (o_counter !== 14'd0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid: got cnt=%0d busy=%0b, want 0 0", o_counter, o_busy);
        end
        for (int i = 0; i < 8; i++) begin
            clk_step();
            n_checks++;
            if ({o_counter, o_terminal, o_busy} !== {m_count, m_term, m_run}) begin
                n_fail++;
                $display("FAIL clear_restart cyc %0d: got cnt=%0d busy=%0b, want cnt=%0d busy=%0b",
                         i, o_counter, o_busy, m_count, m_run);
            end
        end
    endtask

    task automatic test_allow_drop();
        do_clear();
        sel = Div1; data = 14'd50; mode = Cnt_Wrap; allow = 1'b1;
        for (int i = 0; i < 50 && o_counter != 14'd4; i++) clk_step();
        allow = 1'b0;
        for (int i = 0; i < 10; i++) clk_step();
        n_checks++;
        if (o_counter !== 14'd4 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL allow_hold: got cnt=%0d busy=%0b, want 4 0", o_counter, o_busy);
        end
        allow = 1'b1;
        clk_step();
        n_checks++;
        if (o_counter !== 14'd4 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL allow_resume: got cnt=%0d busy=%0b, want 4 1", o_counter, o_busy);
        end
        clk_step();
        n_checks++;
        if (o_counter !== 14'd5) begin
            n_fail++;
            $display("FAIL allow_next_inc: got cnt=%0d, want 5", o_counter);
        end
    endtask

    task automatic test_data_lower();
        do_clear();
        sel = Div1; data = 14'd100; mode = Cnt_Wrap; allow = 1'b1;
        for (int i = 0; i < 50 && o_counter != 14'd20; i++) clk_step();
        data = 14'd10;
        clk_step();
        n_checks++;
        if (o_terminal !== 1'b1 || o_counter !== 14'd0) begin
            n_fail++;
            $display("FAIL data_lower: got term=%0b cnt=%0d, want 1 0", o_terminal, o_counter);
        end
    endtask

    task automatic test_zero_data();
        do_clear();
        sel = Div2; data = 14'd0; mode = Cnt_Wrap; allow = 1'b1;
        for (int i = 0; i < 9; i++) begin
            clk_step();
            n_checks++;
            if ({o_counter, o_terminal, o_busy} !== {m_count, m_term, m_run}) begin
                n_fail++;
                $display("FAIL zero_data cyc %0d: got cnt=%0d term=%0b, want cnt=%0d term=%0b",
                         i, o_counter, o_terminal, m_count, m_term);
            end
        end
        for (int i = 0; i < 4 && o_terminal != 1'b1; i++) clk_step();
        rst_n = 1'b0;
        clk_step();
        rst_n = 1'b1;
        n_checks++;
        if (o_terminal !== 1'b0 || o_counter !== 14'd0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reset_pulse: got term=%0b cnt=%0d busy=%0b, want 0 0 0", o_terminal, o_counter, o_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(99) != 0);
            cnt_reset = ($urandom_range(59) != 0);
            allow     = ($urandom_range(9) < 8);
            if ($urandom_range(19) == 0) data = 14'($urandom_range(12));
            if ($urandom_range(29) == 0) sel = cnt_prescale_e'(3'($urandom_range(7)));
            if ($urandom_range(39) == 0) mode = cnt_mode_e'(1'($urandom_range(1)));
            clk_step();
            n_checks++;
            if ({o_counter, o_terminal, o_busy} !== {m_count, m_term, m_run}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got cnt=%0d term=%0b busy=%0b, want cnt=%0d term=%0b busy=%0b",
                         i, o_counter, o_terminal, o_busy, m_count, m_term, m_run);
            end
        end
        rst_n = 1'b1; cnt_reset = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_wrap_n1();
        test_one_shot_n4();
        test_clear_mid();
        test_allow_drop();
        test_data_lower();
        test_zero_data();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
